div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 132 +++++++++++++
 tb/tb_div_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit integer divider for the execute stage (DIV / DIVU).
//
// A radix-2 restoring divider works on operand magnitudes. Signs are fixed up when the
// result is presented: the quotient is negated when the operand signs differ, and the
// remainder takes the sign of the dividend.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   divide instruction valid (held high while the pipeline is stalled)
//   signed_div in   1 = DIV (signed), 0 = DIVU (unsigned)
//   annul      in   cancel the in-flight divide
//   opdata1    in   [31:0] dividend
//   opdata2    in   [31:0] divisor
//   result     out  [63:0] {remainder, quotient}
//   ready      out  one-cycle pulse, result valid
//   stall_div  out  stall request to the hazard unit
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall_div
);

    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} stateType;

    stateType    stateQ, stateD;
    logic [4:0]  countQ;
    logic [31:0] quotQ;     // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] remQ;      // partial remainder magnitude
    logic [31:0] divisorQ;  // divisor magnitude
    logic        negQuotQ;
    logic        negRemQ;
    logic [63:0] resultQ;

    logic        aNeg, bNeg;
    logic [31:0] aMag, bMag;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        fits;
    logic [31:0] newRem, newQuot;
    logic [31:0] quotFinal, remFinal;
    logic        presenting;

    // Operand magnitudes; -32'h80000000 wraps to itself, which is the correct magnitude.
    assign aNeg = signed_div & opdata1[31];
    assign bNeg = signed_div & opdata2[31];
    assign aMag = aNeg ? -opdata1 : opdata1;
    assign bMag = bNeg ? -opdata2 : opdata2;

    // One restoring step. The partial remainder stays below the divisor, so the 33-bit
    // shifted value is below twice the divisor and both outcomes fit in 32 bits.
    assign shifted = {remQ, quotQ[31]};
    assign trial   = shifted - {1'b0, divisorQ};
    assign fits    = (shifted >= {1'b0, divisorQ});
    assign newRem  = fits ? trial[31:0] : shifted[31:0];
    assign newQuot = {quotQ[30:0], fits};

    assign quotFinal = negQuotQ ? -quotQ : quotQ;
    assign remFinal  = negRemQ ? -remQ : remQ;

    // The finished value is shown in END directly so it is valid alongside ready; it is
    // committed to resultQ only if the END cycle is not annulled.
    assign presenting = (stateQ == StEnd) & ~annul & ~rst;
    assign ready      = presenting;
    assign result     = presenting ? {remFinal, quotFinal} : resultQ;
    assign stall_div  = start & ~ready & ~annul;

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (start && !annul) begin
                    stateD = (opdata2 == 32'd0) ? StByZero : StOn;
                end
            end
            StByZero: stateD = annul ? StIdle : StEnd;
            StOn: begin
                if (annul) begin
                    stateD = StIdle;
                end else if (countQ == 5'd31) begin
                    stateD = StEnd;
                end
            end
            StEnd: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            countQ   <= 5'd0;
            quotQ    <= 32'd0;
            remQ     <= 32'd0;
            divisorQ <= 32'd0;
            negQuotQ <= 1'b0;
            negRemQ  <= 1'b0;
            resultQ  <= 64'd0;
        end else begin
            if (stateQ == StIdle && start && !annul) begin
                countQ   <= 5'd0;
                remQ     <= 32'd0;
                divisorQ <= bMag;
                negQuotQ <= aNeg ^ bNeg;
                negRemQ  <= aNeg;
                // A zero dividend register makes the by-zero result come out as 0.
                quotQ    <= (opdata2 == 32'd0) ? 32'd0 : aMag;
            end else if (stateQ == StOn && !annul) begin
                quotQ  <= newQuot;
                remQ   <= newRem;
                countQ <= countQ + 5'd1;
            end
            if (presenting) begin
                resultQ <= {remFinal, quotFinal};
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes expected results, a negedge monitor
// pops and compares them whenever ready is seen.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opdata1 = 32'd0;
    logic [31:0] opdata2 = 32'd0;
    logic [63:0] result;
    logic        ready;
    logic        stall_div;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    logic [63:0] lastResult = 64'd0;

    typedef struct {
        logic [63:0] value;
        int          cycle;
    } expT;
    expT expQ[$];

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .annul     (annul),
        .opdata1   (opdata1),
        .opdata2   (opdata2),
        .result    (result),
        .ready     (ready),
        .stall_div (stall_div)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    // Reference: plain integer arithmetic, truncating division.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Monitor: every ready pulse must match the oldest expected entry, value and cycle.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected none (cycle %0d)", cycle);
            end else begin
                expT e;
                e = expQ.pop_front();
                chk("result", result, e.value);
                chk("ready_cycle", 64'(cycle), 64'(e.cycle));
            end
        end
    end

    // Issue one divide starting next cycle; returns in the ready cycle.
    task automatic doDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input bit hold);
        int          lat;
        logic [63:0] expv;
        lat  = (b == 32'd0) ? 2 : 33;
        expv = refDiv(a, b, sgn);
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b0;
        opdata1 = a; opdata2 = b; signed_div = sgn;
        expQ.push_back('{value: expv, cycle: cycle + lat});
        #1;
        chk("stall_c0", 64'(stall_div), 64'd1);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
            // Latched operands must be immune to later input changes.
            opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
            #1;
            chk("stall", 64'(stall_div), 64'(start && (k < lat)));
            if (k < lat) chk("result_hold", result, lastResult);
        end
        start = 1'b0;
        lastResult = expv;
    endtask

    task automatic annulAt(input int at);
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0;
        for (int k = 1; k <= at; k++) begin
            @(posedge clk); #1;
        end
        annul = 1'b1;
        #1;
        chk("annul_stall", 64'(stall_div), 64'd0);
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result", result, lastResult);
    endtask

    task automatic resetAt(input int at);
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b0; opdata1 = 32'd5000; opdata2 = 32'd7; signed_div = 1'b0;
        for (int k = 1; k <= at; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        #1;
        chk("rst_result", result, 64'd0);
        chk("rst_ready_after", 64'(ready), 64'd0);
        lastResult = 64'd0;
    endtask

    initial begin
        logic [31:0] a, b;
        int          sel;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_stall", 64'(stall_div), 64'd0);
        rst = 1'b0;

        doDiv(32'd100, 32'd7, 1'b0, 1'b1);
        doDiv(32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b1);
        doDiv(32'h12345678, 32'd0, 1'b0, 1'b1);
        doDiv(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
        doDiv(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);

        annulAt(10);
        doDiv(32'hDEADBEEF, 32'd13, 1'b0, 1'b1);

        // Annul in IDLE with start high must not launch an operation.
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
        #1;
        chk("idle_annul_stall", 64'(stall_div), 64'd0);
        doDiv(32'd77, 32'd8, 1'b0, 1'b1);

        resetAt(15);
        doDiv(32'd9, 32'd3, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 16));
                2:       b = 32'hFFFFFFFF;
                3:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            if (sel == 4) a = 32'h80000000;
            doDiv(a, b, 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
